// File: rtl/uart_frame_sched.sv
// Frame scheduler between colour detection and the UART transmitter: round-robin
// arbitration of colour/error requests, byte-wise frame serialisation with gap and timeout.
module uart_frame_sched #(
    parameter int   GAP_CYCLES = 2,
    parameter int   TIMEOUT    = 64,
    parameter logic PARITY     = 1'b0
) (
    input  logic       clk_3125,
    input  logic       rst_n,
    input  logic       col_req,
    input  logic [1:0] col_code,
    input  logic [3:0] node_id,
    input  logic       err_req,
    input  logic [7:0] err_code,
    output logic       col_busy,
    output logic       err_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       parity_type,
    input  logic       tx_done,
    output logic       frame_done,
    output logic       tx_fault
);
    typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

    localparam logic SEL_COL = 1'b0;
    localparam logic SEL_ERR = 1'b1;
    localparam int   TW      = $clog2(TIMEOUT);
    localparam int   GW      = $clog2(GAP_CYCLES + 2);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t        state, state_n;
    logic          last_grant, grant, grant_n;
    logic [2:0]    idx, last_idx;
    logic          frame_end;
    logic [TW-1:0] to_cnt;
    logic [GW-1:0] gap_cnt;
    logic          do_grant, byte_ok, byte_last, to_fire;
    logic [1:0]    col_code_q;
    logic [3:0]    node_id_q;
    logic [7:0]    err_code_q;
    logic [7:0]    col_char, hex_char, frame_byte;

    always_ff @(posedge clk_3125 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SEL_ERR;
            grant      <= SEL_COL;
            idx        <= 3'd0;
            frame_end  <= 1'b0;
            to_cnt     <= '0;
            gap_cnt    <= '0;
            col_busy   <= 1'b0;
            err_busy   <= 1'b0;
            frame_done <= 1'b0;
            tx_fault   <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            frame_done <= byte_last;
            if (to_fire)
                tx_fault <= 1'b1;
            if (do_grant) begin
                last_grant <= grant_n;
                idx        <= 3'd0;
                frame_end  <= 1'b0;
            end else if (byte_ok) begin
                idx <= idx + 3'd1;
            end else if (byte_last || to_fire) begin
                frame_end <= 1'b1;
            end
            to_cnt  <= (state == WAIT) ? to_cnt + 1'b1 : '0;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            // A finishing frame frees its requester; capture only happens while not busy.
            if ((byte_last || to_fire) && grant == SEL_COL)
                col_busy <= 1'b0;
            else if (col_req && !col_busy)
                col_busy <= 1'b1;
            if ((byte_last || to_fire) && grant == SEL_ERR)
                err_busy <= 1'b0;
            else if (err_req && !err_busy)
                err_busy <= 1'b1;
        end
    end

    always_ff @(posedge clk_3125) begin
        if (col_req && !col_busy) begin
            col_code_q <= col_code;
            node_id_q  <= node_id;
        end
        if (err_req && !err_busy)
            err_code_q <= err_code;
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant;
        do_grant  = 1'b0;
        byte_ok   = 1'b0;
        byte_last = 1'b0;
        to_fire   = 1'b0;
        last_idx  = (grant == SEL_COL) ? 3'd4 : 3'd2;
        case (state)
            IDLE: begin
                if (col_busy && (!err_busy || last_grant == SEL_ERR)) begin
                    do_grant = 1'b1;
                    grant_n  = SEL_COL;
                    state_n  = START;
                end else if (err_busy) begin
                    do_grant = 1'b1;
                    grant_n  = SEL_ERR;
                    state_n  = START;
                end
            end
            START: state_n = WAIT;
            WAIT: begin
                // tx_done wins over a timeout landing on the same cycle.
                if (tx_done) begin
                    byte_last = (idx == last_idx);
                    byte_ok   = (idx != last_idx);
                    if (GAP_CYCLES == 0)
                        state_n = (idx == last_idx) ? IDLE : START;
                    else
                        state_n = GAP;
                end else if (to_cnt == TO_LAST) begin
                    to_fire = 1'b1;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST)
                    state_n = frame_end ? IDLE : START;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        case (col_code_q)
            2'd1:    col_char = 8'h47;
            2'd2:    col_char = 8'h42;
            2'd3:    col_char = 8'h57;
            default: col_char = 8'h52;
        endcase
        hex_char = (node_id_q < 4'd10) ? 8'h30 + {4'h0, node_id_q} : 8'h37 + {4'h0, node_id_q};
        frame_byte = 8'h23;
        if (grant == SEL_COL) begin
            case (idx)
                3'd0:    frame_byte = 8'h43;
                3'd1:    frame_byte = col_char;
                3'd2:    frame_byte = 8'h4E;
                3'd3:    frame_byte = hex_char;
                default: frame_byte = 8'h23;
            endcase
        end else begin
            case (idx)
                3'd0:    frame_byte = 8'h45;
                3'd1:    frame_byte = err_code_q;
                default: frame_byte = 8'h23;
            endcase
        end
    end

    assign tx_start    = (state == START);
    assign tx_data     = (state == IDLE) ? 8'h00 : frame_byte;
    assign parity_type = PARITY;
endmodule
